nanorv32_ahb_ram_responder: RTL

AHB-Lite responder (slave) that terminates the nanorv32 data-side initiator bus and serves it from an internal word-organised RAM. It samples address phases, inserts a programmable number of wait states, performs byte/halfword/word reads and writes, and returns a two-cycle ERROR for misaligned or out-of-range accesses. It sits on the chip bus beside the code RAM and gives the CPU's `htransd`/`hwrited`/`hreadyd` data port a zero-or-N-wait-state target.

---
 rtl/nanorv32_ahb_ram_responder_pkg.sv | 42 ++++
 rtl/nanorv32_ahb_ram_array.sv | 24 ++
 rtl/nanorv32_ahb_ram_responder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/nanorv32_ahb_ram_responder_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and lane-enable helper
// for the nanorv32 data-side RAM responder.
package nanorv32_ahb_ram_responder_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_e;

  // Byte lanes touched by an aligned access; unsupported sizes touch nothing.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/nanorv32_ahb_ram_array.sv
// Word-organised RAM with per-byte write enables and an asynchronous read
// port, so a write committed at one edge is visible to the very next cycle.
module nanorv32_ahb_ram_array #(
  parameter int MEM_WORDS_LOG2 = 12
) (
  input  logic                      i_clk,
  input  logic [3:0]                i_we,
  input  logic [MEM_WORDS_LOG2-1:0] i_addr,
  input  logic [31:0]               i_wdata,
  output logic [31:0]               o_rdata
);

  logic [31:0] r_mem [2**MEM_WORDS_LOG2];

  // Byte-lane writes; contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/nanorv32_ahb_ram_responder.sv
// AHB-Lite responder serving the nanorv32 data port from internal RAM,
// with programmable wait states and two-cycle ERROR responses.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready; completes a pending data phase when pend_valid is set
// WAIT  | stalling an OKAY transfer; counter counts down to zero
// ERR1  | first ERROR cycle, hreadyout low
// ERR2  | second ERROR cycle, hreadyout high; may accept a new transfer
module nanorv32_ahb_ram_responder
  import nanorv32_ahb_ram_responder_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int ADDR_WIDTH     = 32,
  parameter int WAIT_STATES    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_hsel,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [1:0]            i_htrans,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [31:0]           i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hreadyout,
  output logic [31:0]           o_hrdata,
  output logic                  o_hresp
);

  state_e                    r_state, w_state_nxt;
  logic [3:0]                r_wait_cnt, w_wait_cnt_nxt;
  logic                      r_pend_valid, w_pend_valid_nxt;
  logic                      r_pend_write;
  logic [2:0]                r_pend_size;
  logic [MEM_WORDS_LOG2+1:0] r_pend_addr;

  logic                      w_accept;
  logic                      w_capture;
  logic                      w_addr_err;
  logic [ADDR_WIDTH:0]       w_limit;
  logic                      w_complete;
  logic [3:0]                w_we;
  logic [31:0]               w_rdata;

  assign w_accept = i_hsel && i_hready &&
                    (i_htrans != HTRANS_IDLE) && (i_htrans != HTRANS_BUSY);

  // One bit wider than haddr so the limit never overflows.
  assign w_limit    = {{(ADDR_WIDTH-2){1'b0}}, 3'b100} << MEM_WORDS_LOG2;
  assign w_addr_err = (i_hsize > HSIZE_WORD) ||
                      ((i_hsize == HSIZE_HALF) && i_haddr[0]) ||
                      ((i_hsize == HSIZE_WORD) && (i_haddr[1:0] != 2'b00)) ||
                      ({1'b0, i_haddr} >= w_limit);

  // Next-state, counter and handshake outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_pend_valid_nxt = r_pend_valid;
    w_capture        = 1'b0;
    o_hreadyout      = 1'b1;
    o_hresp          = HRESP_OKAY;
    case (r_state)
      S_IDLE, S_ERR2: begin
        if (r_state == S_ERR2) o_hresp = HRESP_ERROR;
        w_state_nxt      = S_IDLE;
        w_pend_valid_nxt = 1'b0;
        if (w_accept) begin
          w_capture = 1'b1;
          if (w_addr_err) begin
            w_state_nxt = S_ERR1;
          end else begin
            w_pend_valid_nxt = 1'b1;
            if (WAIT_STATES > 0) begin
              w_state_nxt    = S_WAIT;
              w_wait_cnt_nxt = 4'(WAIT_STATES - 1);
            end
          end
        end
      end
      S_WAIT: begin
        o_hreadyout = 1'b0;
        if (r_wait_cnt == 4'd0) w_state_nxt = S_IDLE;
        else                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
      end
      S_ERR1: begin
        o_hreadyout = 1'b0;
        o_hresp     = HRESP_ERROR;
        w_state_nxt = S_ERR2;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, wait counter and pending address-phase registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= 4'd0;
      r_pend_valid <= 1'b0;
      r_pend_write <= 1'b0;
      r_pend_size  <= 3'd0;
      r_pend_addr  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      if (w_capture) begin
        r_pend_write <= i_hwrite;
        r_pend_size  <= i_hsize;
        r_pend_addr  <= i_haddr[MEM_WORDS_LOG2+1:0];
      end
    end
  end

  // A data phase completes in IDLE while a transfer is pending; reset
  // in that same cycle suppresses the write.
  assign w_complete = (r_state == S_IDLE) && r_pend_valid;
  assign w_we       = (w_complete && r_pend_write && !i_rst) ?
                      byte_en(r_pend_size, r_pend_addr[1:0]) : 4'b0000;
  assign o_hrdata   = (w_complete && !r_pend_write) ? w_rdata : 32'h0;

  nanorv32_ahb_ram_array #(
    .MEM_WORDS_LOG2(MEM_WORDS_LOG2)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (w_we),
    .i_addr (r_pend_addr[MEM_WORDS_LOG2+1:2]),
    .i_wdata(i_hwdata),
    .o_rdata(w_rdata)
  );

endmodule
